// File: rtl/rename_arbiter_if.sv
// Handshake bundle between decode/ROB-retire, the rename arbiter and the rename unit.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface rename_arbiter_if;
  logic       dec_valid;
  logic       dec_ready;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;

  logic       ret_valid;
  logic       ret_ready;
  logic [5:0] ret_phys_reg;

  logic       rn_issue_valid;
  logic       rn_retire_valid;
  logic [4:0] rn_rs1;
  logic [4:0] rn_rs2;
  logic [4:0] rn_rd;
  logic [5:0] rn_retire_phys_reg;
  logic       rn_rename_valid;

  logic       stall;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    output ret_valid, ret_phys_reg,
    output rn_rename_valid,
    input  dec_ready, ret_ready,
    input  rn_issue_valid, rn_retire_valid, rn_rs1, rn_rs2, rn_rd, rn_retire_phys_reg,
    input  stall
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  ret_valid, ret_phys_reg,
    input  rn_rename_valid,
    output dec_ready, ret_ready,
    output rn_issue_valid, rn_retire_valid, rn_rs1, rn_rs2, rn_rd, rn_retire_phys_reg,
    output stall
  );
endinterface

// File: rtl/rename_arbiter.sv
// Rename sequencer: one-entry decode slot plus retire FIFO, granting ISSUE xor RETIRE each cycle.
// Define RENAME_ARB_PERF_EN to add the perf_issue_cnt_o / perf_stall_cnt_o counters.
module rename_arbiter #(
  parameter int unsigned RET_DEPTH        = 4,
  parameter int unsigned MAX_ISSUE_STREAK = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  rename_arbiter_if.slave    bus
`ifdef RENAME_ARB_PERF_EN
  ,
  output logic [31:0]        perf_issue_cnt_o,
  output logic [31:0]        perf_stall_cnt_o
`endif
);

  localparam int unsigned PtrW    = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(RET_DEPTH + 1);
  localparam int unsigned StreakW = (MAX_ISSUE_STREAK > 0) ? $clog2(MAX_ISSUE_STREAK + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StRetire, StStall} state_e;

  state_e               state_q, state_d;
  logic                 slot_valid_q, slot_valid_d;
  logic [4:0]           slot_rs1_q, slot_rs2_q, slot_rd_q;
  logic [5:0]           fifo_mem_q [RET_DEPTH];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [5:0]           ret_head_q, head_val;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic                 stall_q, stall_d;

  logic in_issue, in_retire, issue_ok, issue_fail;
  logic dec_hs, push, pop, fifo_avail;

  assign in_issue   = (state_q == StIssue);
  assign in_retire  = (state_q == StRetire);
  assign issue_ok   = in_issue & bus.rn_rename_valid;
  assign issue_fail = in_issue & ~bus.rn_rename_valid;

  assign bus.dec_ready = ~slot_valid_q | issue_ok;
  assign bus.ret_ready = (count_q != CntW'(RET_DEPTH));

  assign dec_hs = bus.dec_valid & bus.dec_ready;
  assign push   = bus.ret_valid & bus.ret_ready;

  // A push into an empty FIFO can be granted at the same edge, so bypass the head.
  assign fifo_avail = (count_q != '0) | push;
  assign head_val   = (count_q == '0) ? bus.ret_phys_reg : fifo_mem_q[rd_ptr_q];

  assign slot_valid_d = dec_hs | (slot_valid_q & ~issue_ok);
  assign stall_d      = issue_fail | (stall_q & ~in_retire);

  always_comb begin
    state_d = StIdle;
    if (stall_d) begin
      state_d = fifo_avail ? StRetire : StStall;
    end else if (fifo_avail &&
                 (!slot_valid_d || streak_q == StreakW'(MAX_ISSUE_STREAK))) begin
      state_d = StRetire;
    end else if (slot_valid_d) begin
      state_d = StIssue;
    end
  end

  assign pop = (state_d == StRetire);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (pop) begin
      streak_d = '0;
    end else if (state_d == StIssue && streak_q != StreakW'(MAX_ISSUE_STREAK)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      slot_valid_q <= 1'b0;
      slot_rs1_q   <= '0;
      slot_rs2_q   <= '0;
      slot_rd_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ret_head_q   <= '0;
      streak_q     <= '0;
      stall_q      <= 1'b0;
      for (int unsigned i = 0; i < RET_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      count_q      <= count_d;
      streak_q     <= streak_d;
      stall_q      <= stall_d;
      if (dec_hs) begin
        slot_rs1_q <= bus.dec_rs1;
        slot_rs2_q <= bus.dec_rs2;
        slot_rd_q  <= bus.dec_rd;
      end
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= bus.ret_phys_reg;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        ret_head_q <= head_val;
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign bus.rn_issue_valid     = in_issue;
  assign bus.rn_retire_valid    = in_retire;
  assign bus.rn_rs1             = in_issue ? slot_rs1_q : '0;
  assign bus.rn_rs2             = in_issue ? slot_rs2_q : '0;
  assign bus.rn_rd              = in_issue ? slot_rd_q : '0;
  assign bus.rn_retire_phys_reg = in_retire ? ret_head_q : '0;
  assign bus.stall              = stall_q;

`ifdef RENAME_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (issue_ok) perf_issue_q <= perf_issue_q + 32'd1;
      if (stall_q)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_cnt_o = perf_issue_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_rename_arbiter.sv
// Bench for rename_arbiter: per-cycle vector table plus hand sequences around a small
// negedge rename-unit model (32 free physical regs p32..p63).
module tb_rename_arbiter;

  logic clk;
  logic reset_n;
  logic use_model;
  logic force_rv;
  logic model_ok;
  logic [5:0] last_phys;
  logic [5:0] fl [64];
  logic [31:0] fl_head, fl_tail;
  int unsigned n_pass;
  int unsigned n_total;

  rename_arbiter_if bus ();

  assign bus.rn_rename_valid = use_model ? model_ok : force_rv;

`ifdef RENAME_ARB_PERF_EN
  logic [31:0] perf_issue, perf_stall;
`endif

  rename_arbiter #(
    .RET_DEPTH        (4),
    .MAX_ISSUE_STREAK (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef RENAME_ARB_PERF_EN
    ,
    .perf_issue_cnt_o (perf_issue),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rename unit model: grants from its free list on negedge, retires return regs to it.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) fl[i] <= 6'(32 + i);
      fl_head   <= 32'd0;
      fl_tail   <= 32'd32;
      model_ok  <= 1'b0;
      last_phys <= 6'd0;
    end else begin
      model_ok <= 1'b0;
      if (bus.rn_issue_valid && fl_tail != fl_head) begin
        model_ok  <= 1'b1;
        last_phys <= fl[fl_head[5:0]];
        fl_head   <= fl_head + 32'd1;
      end
      if (bus.rn_retire_valid) begin
        fl[fl_tail[5:0]] <= bus.rn_retire_phys_reg;
        fl_tail          <= fl_tail + 32'd1;
      end
    end
  end

  typedef struct packed {
    logic       rst;
    logic       dv;
    logic [4:0] rd;
    logic       rv;
    logic [5:0] phys;
    logic [1:0] exp_op;    // {retire, issue}
    logic [4:0] exp_rd;
    logic [5:0] exp_phys;
    logic       exp_dr;
    logic       exp_rr;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic rst, input logic dv, input int rd, input logic rv,
                              input int phys, input int op, input int erd, input int ephys,
                              input logic dr, input logic rr);
    vec_t v;
    v.rst = rst; v.dv = dv; v.rd = 5'(rd); v.rv = rv; v.phys = 6'(phys);
    v.exp_op = 2'(op); v.exp_rd = 5'(erd); v.exp_phys = 6'(ephys);
    v.exp_dr = dr; v.exp_rr = rr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input int rd, input logic rv, input int phys);
    bus.dec_valid    = dv;
    bus.dec_rs1      = 5'd0;
    bus.dec_rs2      = 5'd0;
    bus.dec_rd       = 5'(rd);
    bus.ret_valid    = rv;
    bus.ret_phys_reg = 6'(phys);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    next_cyc();
    next_cyc();
    reset_n = 1'b1;
  endtask

  task automatic apply(input int i);
    if (vecs[i].rst) do_reset();
    drive(vecs[i].dv, int'(vecs[i].rd), vecs[i].rv, int'(vecs[i].phys));
    #1;
    chk($sformatf("v%0d_op", i), 32'({bus.rn_retire_valid, bus.rn_issue_valid}),
        32'(vecs[i].exp_op));
    chk($sformatf("v%0d_rd", i), 32'(bus.rn_rd), 32'(vecs[i].exp_rd));
    chk($sformatf("v%0d_phys", i), 32'(bus.rn_retire_phys_reg), 32'(vecs[i].exp_phys));
    chk($sformatf("v%0d_dec_ready", i), 32'(bus.dec_ready), 32'(vecs[i].exp_dr));
    chk($sformatf("v%0d_ret_ready", i), 32'(bus.ret_ready), 32'(vecs[i].exp_rr));
    chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'd0);
    next_cyc();
  endtask

  initial begin
    int hs;
    n_pass    = 0;
    n_total   = 0;
    reset_n   = 1'b0;
    use_model = 1'b0;
    force_rv  = 1'b1;
    drive(1'b0, 0, 1'b0, 0);

    // FIFO fill to 4, push+pop at count 3, drain order
    vecs[0]  = mk(1, 1, 1, 1, 40, 0, 0, 0,  1, 1);
    vecs[1]  = mk(0, 1, 2, 1, 41, 1, 1, 0,  1, 1);
    vecs[2]  = mk(0, 1, 3, 1, 42, 1, 2, 0,  1, 1);
    vecs[3]  = mk(0, 1, 4, 1, 43, 1, 3, 0,  1, 1);
    vecs[4]  = mk(0, 1, 5, 1, 44, 2, 0, 40, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0,  1, 4, 0,  1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 45, 2, 0, 41, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0,  2, 0, 42, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0,  2, 0, 43, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0,  2, 0, 44, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 0,  2, 0, 45, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 1);
    // Slot always full, two retires queued: ISSUE x3, RETIRE, ISSUE x3, RETIRE
    vecs[12] = mk(1, 1, 1, 1, 50, 0, 0, 0,  1, 1);
    vecs[13] = mk(0, 1, 2, 1, 51, 1, 1, 0,  1, 1);
    vecs[14] = mk(0, 1, 3, 0, 0,  1, 2, 0,  1, 1);
    vecs[15] = mk(0, 1, 4, 0, 0,  1, 3, 0,  1, 1);
    vecs[16] = mk(0, 1, 5, 0, 0,  2, 0, 50, 0, 1);
    vecs[17] = mk(0, 1, 5, 0, 0,  1, 4, 0,  1, 1);
    vecs[18] = mk(0, 1, 6, 0, 0,  1, 5, 0,  1, 1);
    vecs[19] = mk(0, 1, 7, 0, 0,  1, 6, 0,  1, 1);
    vecs[20] = mk(0, 1, 8, 0, 0,  2, 0, 51, 0, 1);
    vecs[21] = mk(0, 0, 0, 0, 0,  1, 7, 0,  1, 1);
    vecs[22] = mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 1);

    for (int i = 0; i < 23; i++) apply(i);

    // Reset in the middle of a RETIRE with three entries left in the FIFO
    for (int i = 0; i < 4; i++) apply(i);
    drive(1'b1, 5, 1'b1, 44);
    #1;
    chk("t1_pre_retire", 32'(bus.rn_retire_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t1_rst_op", 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd0);
    chk("t1_rst_phys", 32'(bus.rn_retire_phys_reg), 32'd0);
    chk("t1_rst_rd", 32'(bus.rn_rd), 32'd0);
    chk("t1_rst_ret_ready", 32'(bus.ret_ready), 32'd1);
    chk("t1_rst_dec_ready", 32'(bus.dec_ready), 32'd1);
    drive(1'b0, 0, 1'b0, 0);
    next_cyc();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t1_after_op%0d", c), 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd0);
      chk($sformatf("t1_after_ret_ready%0d", c), 32'(bus.ret_ready), 32'd1);
      next_cyc();
    end

    // Single issue through the rename model
    use_model = 1'b1;
    do_reset();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd1; bus.dec_rs2 = 5'd2; bus.dec_rd = 5'd3;
    next_cyc();
    bus.dec_valid = 1'b0;
    #1;
    chk("t2_issue", 32'(bus.rn_issue_valid), 32'd1);
    chk("t2_rs1", 32'(bus.rn_rs1), 32'd1);
    chk("t2_rs2", 32'(bus.rn_rs2), 32'd2);
    chk("t2_rd", 32'(bus.rn_rd), 32'd3);
    chk("t2_map", 32'(last_phys), 32'd32);
    chk("t2_ok", 32'(bus.rn_rename_valid), 32'd1);
    next_cyc();
    chk("t2_idle", 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd0);

    // 33 back-to-back issues exhaust the free list
    do_reset();
    hs = 0;
    drive(1'b1, 1, 1'b0, 0);
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.stall) break;
      if (bus.dec_valid && bus.dec_ready) hs++;
      next_cyc();
      bus.dec_valid = (hs < 33);
      bus.dec_rd    = 5'((hs % 31) + 1);
    end
    chk("t3_handshakes", 32'(hs), 32'd33);
    chk("t3_stall", 32'(bus.stall), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t3_dec_ready%0d", c), 32'(bus.dec_ready), 32'd0);
      chk($sformatf("t3_op%0d", c), 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd0);
      next_cyc();
    end

    // One retire frees p32; the stalled instruction is retried and gets it
    drive(1'b0, 0, 1'b1, 32);
    #1;
    chk("t4_ret_ready", 32'(bus.ret_ready), 32'd1);
    next_cyc();
    bus.ret_valid = 1'b0;
    #1;
    chk("t4_retire", 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd2);
    chk("t4_phys", 32'(bus.rn_retire_phys_reg), 32'd32);
    next_cyc();
    chk("t4_retry", 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd1);
    chk("t4_retry_rd", 32'(bus.rn_rd), 32'd2);
    chk("t4_stall_clr", 32'(bus.stall), 32'd0);
    chk("t4_map", 32'(last_phys), 32'd32);
    next_cyc();
    chk("t4_idle", 32'({bus.rn_retire_valid, bus.rn_issue_valid}), 32'd0);
    chk("t4_dec_ready", 32'(bus.dec_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
